// File: rtl/syncer_event_multi.sv
// Multi-channel event synchronizer: per-channel sync chain, runtime edge detect, pulse stretch,
// sticky overrun flags and saturating event counters with registered readback.
module syncer_event_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_CH-1:0]  evt_async_in,
  input  logic [1:0]       edge_mode,
  input  logic [N_CH-1:0]  evt_mask,
  output logic [N_CH-1:0]  pulse_out,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  overrun,
  input  logic [N_CH-1:0]  overrun_clr,
  input  logic [SEL_W-1:0] cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_value
);

  localparam int LEN_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_RELOAD = LEN_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic {ST_IDLE, ST_ACTIVE} st_e;

  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [SYNC_STAGES-1:0] sync_d [N_CH];
  logic [N_CH-1:0]        prev_q, prev_d;
  logic [N_CH-1:0]        s_lvl, det, ovr_set;
  st_e                    state_q [N_CH];
  st_e                    state_d [N_CH];
  logic [LEN_W-1:0]       len_q [N_CH];
  logic [LEN_W-1:0]       len_d [N_CH];
  logic [N_CH-1:0]        ovr_q, ovr_d;
  logic [CNT_W-1:0]       cnt_q [N_CH];
  logic [CNT_W-1:0]       cnt_d [N_CH];
  logic [CNT_W-1:0]       cnt_value_q, cnt_value_d;

  function automatic logic edge_match(input logic [1:0] mode, input logic p, input logic c);
    unique case (mode)
      2'd0:    return p ^ c;
      2'd1:    return ~p & c;
      2'd2:    return p & ~c;
      default: return 1'b0;
    endcase
  endfunction

  // Synchronize and detect; prev follows s unconditionally so mask/mode changes never fake an edge.
  always_comb begin
    s_lvl  = '0;
    det    = '0;
    prev_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], evt_async_in[i]};
      s_lvl[i]  = sync_q[i][SYNC_STAGES-1];
      prev_d[i] = s_lvl[i];
      det[i]    = ~evt_mask[i] & edge_match(edge_mode, prev_q[i], s_lvl[i]);
    end
  end

  // Stretch FSM, overrun and counters per channel.
  always_comb begin
    ovr_set = '0;
    ovr_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      len_d[i]   = len_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_IDLE: begin
          if (det[i]) begin
            state_d[i] = ST_ACTIVE;
            len_d[i]   = LEN_RELOAD;
          end
        end
        ST_ACTIVE: begin
          if (len_q[i] != '0) begin
            len_d[i]   = len_q[i] - 1'b1;
            ovr_set[i] = det[i];
          end else if (det[i]) begin
            len_d[i]   = LEN_RELOAD;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
      ovr_d[i] = ovr_set[i] | (ovr_q[i] & ~overrun_clr[i]);
      if (cnt_clr && (cnt_sel == SEL_W'(i))) begin
        cnt_d[i] = det[i] ? CNT_W'(1) : '0;
      end else if (det[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    cnt_value_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_sel == SEL_W'(i)) cnt_value_d = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= ST_IDLE;
        len_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      prev_q      <= '0;
      ovr_q       <= '0;
      cnt_value_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i]  <= sync_d[i];
        state_q[i] <= state_d[i];
        len_q[i]   <= len_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      prev_q      <= prev_d;
      ovr_q       <= ovr_d;
      cnt_value_q <= cnt_value_d;
    end
  end

  always_comb begin
    pulse_out = '0;
    for (int i = 0; i < N_CH; i++) pulse_out[i] = (state_q[i] == ST_ACTIVE);
  end

  assign busy      = pulse_out;
  assign overrun   = ovr_q;
  assign cnt_value = cnt_value_q;

endmodule

// File: tb/tb_syncer_event_multi.sv
// Directed plus randomized bench for syncer_event_multi against a remaining-cycles reference model.
module tb_syncer_event_multi;

  localparam int N_CH  = 5;
  localparam int SS    = 2;
  localparam int PLEN  = 4;
  localparam int CNT_W = 3;
  localparam int SEL_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             resetn;
  logic [N_CH-1:0]  evt_async_in;
  logic [1:0]       edge_mode;
  logic [N_CH-1:0]  evt_mask;
  logic [N_CH-1:0]  pulse_out;
  logic [N_CH-1:0]  busy;
  logic [N_CH-1:0]  overrun;
  logic [N_CH-1:0]  overrun_clr;
  logic [SEL_W-1:0] cnt_sel;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_value;

  int n_cmp = 0;
  int n_err = 0;
  int trk   = 0;
  int pc    = 0;

  syncer_event_multi #(.N_CH(N_CH), .SYNC_STAGES(SS), .PULSE_LEN(PLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .evt_async_in(evt_async_in), .edge_mode(edge_mode),
    .evt_mask(evt_mask), .pulse_out(pulse_out), .busy(busy), .overrun(overrun),
    .overrun_clr(overrun_clr), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  // Reference model: input history, remaining pulse cycles, plain integer counters.
  logic [63:0]      hist [N_CH];
  int               rem  [N_CH];
  int               cnt  [N_CH];
  logic [N_CH-1:0]  m_ov;
  logic [CNT_W-1:0] m_cv;
  logic [N_CH-1:0]  m_det;
  logic [N_CH-1:0]  m_pulse;
  int               m_sel_cnt;

  always_comb begin
    logic sv, pv;
    m_det     = '0;
    m_pulse   = '0;
    m_sel_cnt = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      sv = hist[ch][SS-1];
      pv = hist[ch][SS];
      case (edge_mode)
        2'd0:    m_det[ch] = (sv != pv);
        2'd1:    m_det[ch] = sv && !pv;
        2'd2:    m_det[ch] = !sv && pv;
        default: m_det[ch] = 1'b0;
      endcase
      if (evt_mask[ch]) m_det[ch] = 1'b0;
      m_pulse[ch] = (rem[ch] > 0);
      if (int'(cnt_sel) == ch) m_sel_cnt = cnt[ch];
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        hist[ch] <= '0;
        rem[ch]  <= 0;
        cnt[ch]  <= 0;
      end
      m_ov <= '0;
      m_cv <= '0;
    end else begin
      m_cv <= CNT_W'(m_sel_cnt);
      for (int ch = 0; ch < N_CH; ch++) begin
        hist[ch] <= {hist[ch][62:0], evt_async_in[ch]};
        if (m_det[ch] && rem[ch] <= 1) rem[ch] <= PLEN;
        else if (rem[ch] > 0)          rem[ch] <= rem[ch] - 1;
        m_ov[ch] <= (m_ov[ch] && !overrun_clr[ch]) || (m_det[ch] && rem[ch] > 1);
        if (cnt_clr && int'(cnt_sel) == ch) cnt[ch] <= m_det[ch] ? 1 : 0;
        else if (m_det[ch])                 cnt[ch] <= (cnt[ch] >= CMAX) ? CMAX : cnt[ch] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("pulse_out", 32'(pulse_out), 32'(m_pulse));
    check("busy", 32'(busy), 32'(m_pulse));
    check("overrun", 32'(overrun), 32'(m_ov));
    check("cnt_value", 32'(cnt_value), 32'(m_cv));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    pc += int'(pulse_out[trk]);
  endtask

  initial begin
    resetn = 1'b0; evt_async_in = '0; edge_mode = 2'd0; evt_mask = '0;
    overrun_clr = '0; cnt_sel = '0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset pulse_out", 32'(pulse_out), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    check("reset cnt_value", 32'(cnt_value), 32'h0);
    check_all();
    resetn = 1'b1;
    repeat (2) step();

    // Single toggle on ch0: pulse from E0+2 for PLEN cycles.
    trk = 0; pc = 0;
    evt_async_in[0] = 1'b1;
    step(); check("t1 E0 pulse", 32'(pulse_out[0]), 32'h0);
    step(); check("t1 E0+1 pulse", 32'(pulse_out[0]), 32'h0);
    step(); check("t1 E0+2 pulse", 32'(pulse_out[0]), 32'h1);
    repeat (3) step();
    check("t1 E0+5 pulse", 32'(pulse_out[0]), 32'h1);
    step(); check("t1 E0+6 pulse", 32'(pulse_out[0]), 32'h0);
    check("t1 cnt0", 32'(cnt_value), 32'h1);
    check("t1 pulse cycles", 32'(pc), 32'(PLEN));

    // Rising mode on ch1: rise counts, fall ignored.
    edge_mode = 2'd1; cnt_sel = 3'd1; trk = 1; pc = 0;
    evt_async_in[1] = 1'b1; repeat (8) step();
    evt_async_in[1] = 1'b0; repeat (8) step();
    check("t2 cnt1", 32'(cnt_value), 32'h1);
    check("t2 pulse cycles", 32'(pc), 32'(PLEN));

    // Second rise while busy: overrun, no extension; clear loses to a same-cycle set.
    pc = 0;
    evt_async_in[1] = 1'b1; step();
    evt_async_in[1] = 1'b0; step();
    evt_async_in[1] = 1'b1; step();
    step();
    overrun_clr[1] = 1'b1; step();
    overrun_clr[1] = 1'b0;
    check("t3 overrun kept", 32'(overrun[1]), 32'h1);
    repeat (8) step();
    check("t3 cnt1", 32'(cnt_value), 32'h3);
    check("t3 pulse cycles", 32'(pc), 32'(PLEN));
    overrun_clr[1] = 1'b1; step(); overrun_clr[1] = 1'b0; step();
    check("t3 overrun cleared", 32'(overrun[1]), 32'h0);

    // Saturation on ch2, then clear concurrent with a detect.
    edge_mode = 2'd0; cnt_sel = 3'd2; cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    repeat (9) begin
      evt_async_in[2] = ~evt_async_in[2];
      repeat (6) step();
    end
    check("t4 cnt2 saturated", 32'(cnt_value), 32'(CMAX));
    evt_async_in[2] = ~evt_async_in[2];
    step(); step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0; step();
    check("t4 clr with det", 32'(cnt_value), 32'h1);

    // Masked ch3, then unmask and mode changes: never an event.
    trk = 3; pc = 0; evt_mask[3] = 1'b1;
    evt_async_in[3] = 1'b1; repeat (6) step();
    evt_mask[3] = 1'b0; repeat (4) step();
    edge_mode = 2'd2; repeat (4) step();
    edge_mode = 2'd1; repeat (4) step();
    cnt_sel = 3'd3; step(); step();
    check("t5 ch3 pulses", 32'(pc), 32'h0);
    check("t5 cnt3", 32'(cnt_value), 32'h0);
    check("t5 overrun3", 32'(overrun[3]), 32'h0);

    // Randomized traffic, including out-of-range selects.
    for (int k = 0; k < 400; k++) begin
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, 5) == 0) evt_async_in[ch] = ~evt_async_in[ch];
      if ($urandom_range(0, 30) == 0) edge_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0) evt_mask = N_CH'($urandom);
      overrun_clr = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
      cnt_sel = SEL_W'($urandom_range(0, 7));
      cnt_clr = ($urandom_range(0, 9) == 0);
      step();
    end
    cnt_clr = 1'b0; overrun_clr = '0; evt_mask = '0; edge_mode = 2'd0;
    repeat (8) step();

    // Async reset mid-stretch on ch4.
    trk = 4; cnt_sel = 3'd4;
    evt_async_in[4] = ~evt_async_in[4];
    step(); step(); step(); step();
    check("t6 pulse before reset", 32'(pulse_out[4]), 32'h1);
    resetn = 1'b0;
    #1;
    check("t6 pulse after reset", 32'(pulse_out), 32'h0);
    check("t6 busy after reset", 32'(busy), 32'h0);
    check("t6 cnt after reset", 32'(cnt_value), 32'h0);
    check("t6 overrun after reset", 32'(overrun), 32'h0);
    @(negedge clk);
    check_all();
    resetn = 1'b1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
